// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: instruction-memory read port, redirect request and the
// instruction/PC handshake towards Decode.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              dec_ready;

  // Handshake: an instruction/inst_pc pair transfers on a cycle where
  // inst_valid && dec_ready; while inst_valid=1 and dec_ready=0 the pair is
  // held stable, and only a redirect or reset may withdraw it.
  modport master (
    output imem_rd_en, imem_addr, instruction, inst_pc, inst_valid,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, instruction, inst_pc, inst_valid,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, one-cycle imem reads, instruction FIFO and
// redirect/flush. Define INSTR_FETCH_PERF_EN to add the perf_* counters.
module instr_fetch #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_if.master        bus
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tag_pc;
  logic              r_inflight;
  logic [31:0]       r_buf_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_last_inst;
  logic [ADDR_W-1:0] r_last_pc;

  logic [CNT_W-1:0]  w_occ;
  logic              w_valid;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_head_inst;
  logic [ADDR_W-1:0] w_head_pc;
  logic              w_unused_bits;

  // The in-flight word reserves a slot, so a response always finds room.
  always_comb begin
    w_occ       = r_count + CNT_W'(r_inflight);
    w_valid     = (r_count != '0);
    w_issue     = reset_n && !bus.redirect_valid && (w_occ < CNT_W'(FIFO_DEPTH));
    w_push      = r_inflight && !bus.redirect_valid;
    w_pop       = w_valid && bus.dec_ready && !bus.redirect_valid;
    w_head_inst = r_buf_inst[r_rd_ptr];
    w_head_pc   = r_buf_pc[r_rd_ptr];
  end

  assign w_unused_bits   = &{1'b0, bus.redirect_pc[1:0]};

  assign bus.imem_rd_en  = w_issue;
  assign bus.imem_addr   = r_pc;
  assign bus.inst_valid  = w_valid;
  assign bus.instruction = w_valid ? w_head_inst : r_last_inst;
  assign bus.inst_pc     = w_valid ? w_head_pc   : r_last_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc        <= RESET_PC;
      r_tag_pc    <= RESET_PC;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_inst <= '0;
      r_last_pc   <= '0;
    end else begin
      if (w_valid) begin
        r_last_inst <= w_head_inst;
        r_last_pc   <= w_head_pc;
      end
      if (bus.redirect_valid) begin
        r_pc       <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        r_inflight <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_pc     <= r_pc + ADDR_W'(4);
          r_tag_pc <= r_pc;
        end
        r_inflight <= w_issue;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_buf_inst[r_wr_ptr] <= bus.imem_rdata;
      r_buf_pc[r_wr_ptr]   <= r_tag_pc;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop)                      r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_valid && !bus.dec_ready)  r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
